// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: pipeline widths, reset constants and the
// {pc, inst} entry that moves between the skid buffer and the IF/ID register.
package if_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int CNT_W_DEF = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] seqPc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that parks a fetch response while IF/ID is held.
// A push into a full buffer without a simultaneous pop is dropped and flagged.
module fetch_skid_buf
  import if_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t dout_o,
  output logic         full_o,
  output logic         ovf_o
);

  fetch_entry_t entry_q;
  logic         full_q;
  logic         ovf_q;

  // The overflow flag is sticky; only reset clears it, a flush does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (push_i) begin
      if (full_q && !pop_i) begin
        ovf_q <= 1'b1;
      end else begin
        entry_q <= din_i;
        full_q  <= 1'b1;
      end
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign dout_o = entry_q;
  assign full_o = full_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: PC register, synchronous instruction memory request, and the
// IF/ID register with skid replay and wrong-path response dropping.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0]     NOP_INST = NOP_INST_DEF,
  parameter int              CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PC_EN_IF,
  input  logic             reg_FD_EN,
  input  logic             reg_FD_stall,
  input  logic             reg_FD_flush,
  input  logic             Branch_ID,
  input  logic [XLEN-1:0]  PC_branch_ID,
  output logic             imem_en,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  PC_IF,
  output logic [XLEN-1:0]  PC_ID,
  output logic [31:0]      inst_ID,
  output logic             valid_ID,
  output logic             skid_ovf,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             req_v_q;
  logic [XLEN-1:0]  req_pc_q;
  logic [XLEN-1:0]  id_pc_q;
  logic [31:0]      id_inst_q;
  logic             id_valid_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic         issue, resp_v, hold;
  logic         skid_push, skid_pop, skid_full;
  fetch_entry_t resp_entry, skid_entry;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  assign issue      = PC_EN_IF & ~Branch_ID & ~rst;
  assign resp_v     = req_v_q & ~reg_FD_flush;
  assign hold       = reg_FD_stall | ~reg_FD_EN;
  assign resp_entry = '{pc: req_pc_q, inst: imem_rdata};

  // Responses go to the skid when ID is held, or when ID is busy draining it.
  assign skid_push = resp_v & (hold | skid_full);
  assign skid_pop  = ~reg_FD_flush & ~hold & skid_full;

  always_comb begin
    pc_d = pc_q;
    if (Branch_ID) begin
      pc_d = PC_branch_ID;
    end else if (PC_EN_IF) begin
      pc_d = seqPc(pc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      req_v_q  <= 1'b0;
      req_pc_q <= '0;
    end else begin
      pc_q    <= pc_d;
      req_v_q <= issue;
      if (issue) begin
        req_pc_q <= pc_q;
      end
    end
  end

  // IF/ID register: flush beats hold, hold beats load; skid replays first.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_q     <= '0;
      id_inst_q   <= NOP_INST;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (reg_FD_flush) begin
      id_inst_q   <= NOP_INST;
      id_valid_q  <= 1'b0;
      flush_cnt_q <= satInc(flush_cnt_q);
    end else if (hold) begin
      stall_cnt_q <= satInc(stall_cnt_q);
    end else if (skid_full) begin
      id_pc_q    <= skid_entry.pc;
      id_inst_q  <= skid_entry.inst;
      id_valid_q <= 1'b1;
    end else if (resp_v) begin
      id_pc_q    <= req_pc_q;
      id_inst_q  <= imem_rdata;
      id_valid_q <= 1'b1;
    end else begin
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .clear_i (reg_FD_flush),
    .din_i   (resp_entry),
    .dout_o  (skid_entry),
    .full_o  (skid_full),
    .ovf_o   (skid_ovf)
  );

  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign PC_IF     = pc_q;
  assign PC_ID     = id_pc_q;
  assign inst_ID   = id_inst_q;
  assign valid_ID  = id_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: straight-line fetch, load-use stall,
// branch redirect, flush+stall, skid overflow and reset mid-stall.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, Branch_ID;
  logic [31:0] PC_branch_ID;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] PC_IF, PC_ID, inst_ID;
  logic        valid_ID, skid_ovf;
  logic [31:0] stall_cnt, flush_cnt;

  int vectorCount = 0;
  int miscompareCount = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .PC_EN_IF     (PC_EN_IF),
    .reg_FD_EN    (reg_FD_EN),
    .reg_FD_stall (reg_FD_stall),
    .reg_FD_flush (reg_FD_flush),
    .Branch_ID    (Branch_ID),
    .PC_branch_ID (PC_branch_ID),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .PC_IF        (PC_IF),
    .PC_ID        (PC_ID),
    .inst_ID      (inst_ID),
    .valid_ID     (valid_ID),
    .skid_ovf     (skid_ovf),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // ROM word is addi x1,x1,imm with imm = low 12 address bits, so every slot differs.
  function automatic logic [31:0] romWord(input logic [31:0] a);
    return {a[11:0], 5'd1, 3'b000, 5'd1, 7'h13};
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= romWord(imem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pcEn, input logic fdEn, input logic stall,
                               input logic flush, input logic branch, input logic [31:0] target);
    PC_EN_IF     = pcEn;
    reg_FD_EN    = fdEn;
    reg_FD_stall = stall;
    reg_FD_flush = flush;
    Branch_ID    = branch;
    PC_branch_ID = target;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_pc_if", PC_IF, 32'h0);
    checkOutput("rst_valid", {31'b0, valid_ID}, 32'h0);
    checkOutput("rst_inst", inst_ID, NOP);
    checkOutput("rst_pc_id", PC_ID, 32'h0);
    checkOutput("rst_stall_cnt", stall_cnt, 32'h0);
    checkOutput("rst_flush_cnt", flush_cnt, 32'h0);
    checkOutput("rst_ovf", {31'b0, skid_ovf}, 32'h0);
    checkOutput("first_imem_en", {31'b0, imem_en}, 32'h1);
    checkOutput("first_imem_addr", imem_addr, 32'h0);

    tick();
    checkOutput("edge1_valid", {31'b0, valid_ID}, 32'h0);
    checkOutput("edge1_pc_if", PC_IF, 32'h4);
    tick();
    checkOutput("id0_pc", PC_ID, 32'h0);
    checkOutput("id0_valid", {31'b0, valid_ID}, 32'h1);
    checkOutput("id0_inst", inst_ID, romWord(32'h0));
    tick();
    checkOutput("id4_pc", PC_ID, 32'h4);
    tick();
    checkOutput("id8_pc", PC_ID, 32'h8);

    applyStimulus(0, 1, 1, 0, 0, 32'h0);
    tick();
    checkOutput("stall_hold_pc", PC_ID, 32'h8);
    checkOutput("stall_hold_valid", {31'b0, valid_ID}, 32'h1);
    checkOutput("stall_cnt1", stall_cnt, 32'h1);
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    tick();
    checkOutput("skid_replay_pc", PC_ID, 32'hC);
    checkOutput("skid_replay_inst", inst_ID, romWord(32'hC));
    checkOutput("skid_replay_valid", {31'b0, valid_ID}, 32'h1);
    tick();
    checkOutput("no_bubble_pc", PC_ID, 32'h10);
    checkOutput("no_bubble_valid", {31'b0, valid_ID}, 32'h1);
    checkOutput("stall_cnt_after", stall_cnt, 32'h1);

    applyStimulus(1, 1, 0, 1, 1, 32'h100);
    #1;
    checkOutput("branch_no_issue", {31'b0, imem_en}, 32'h0);
    tick();
    checkOutput("flush_valid", {31'b0, valid_ID}, 32'h0);
    checkOutput("flush_inst", inst_ID, NOP);
    checkOutput("flush_cnt1", flush_cnt, 32'h1);
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    #1;
    checkOutput("target_addr", imem_addr, 32'h100);
    checkOutput("target_en", {31'b0, imem_en}, 32'h1);
    tick();
    checkOutput("wrong_path_dropped", {31'b0, valid_ID}, 32'h0);
    tick();
    checkOutput("target_pc_id", PC_ID, 32'h100);
    checkOutput("target_valid", {31'b0, valid_ID}, 32'h1);
    checkOutput("target_inst", inst_ID, romWord(32'h100));

    applyStimulus(0, 1, 1, 0, 0, 32'h0);
    tick();
    checkOutput("fill_skid_hold", PC_ID, 32'h100);
    checkOutput("stall_cnt2", stall_cnt, 32'h2);
    applyStimulus(0, 1, 1, 1, 0, 32'h0);
    tick();
    checkOutput("fs_valid", {31'b0, valid_ID}, 32'h0);
    checkOutput("fs_inst", inst_ID, NOP);
    checkOutput("fs_flush_cnt", flush_cnt, 32'h2);
    checkOutput("fs_stall_cnt", stall_cnt, 32'h2);
    checkOutput("fs_ovf", {31'b0, skid_ovf}, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 32'h0);
    tick();
    checkOutput("fs_skid_empty", {31'b0, valid_ID}, 32'h0);
    checkOutput("fs_pc_if", PC_IF, 32'h108);

    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    tick();
    checkOutput("ovf_stall3", stall_cnt, 32'h3);
    tick();
    checkOutput("ovf_first_held", {31'b0, skid_ovf}, 32'h0);
    tick();
    checkOutput("ovf_second_held", {31'b0, skid_ovf}, 32'h1);
    checkOutput("ovf_stall5", stall_cnt, 32'h5);
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    tick();
    checkOutput("ovf_replay_pc", PC_ID, 32'h108);
    checkOutput("ovf_replay_valid", {31'b0, valid_ID}, 32'h1);
    checkOutput("ovf_sticky", {31'b0, skid_ovf}, 32'h1);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    tick();
    checkOutput("held_again_pc", PC_ID, 32'h108);
    checkOutput("held_again_stall", stall_cnt, 32'h6);

    rst = 1'b1;
    #1;
    checkOutput("rst_blocks_issue", {31'b0, imem_en}, 32'h0);
    tick();
    checkOutput("midrst_pc_if", PC_IF, 32'h0);
    checkOutput("midrst_valid", {31'b0, valid_ID}, 32'h0);
    checkOutput("midrst_inst", inst_ID, NOP);
    checkOutput("midrst_pc_id", PC_ID, 32'h0);
    checkOutput("midrst_stall_cnt", stall_cnt, 32'h0);
    checkOutput("midrst_flush_cnt", flush_cnt, 32'h0);
    checkOutput("midrst_ovf", {31'b0, skid_ovf}, 32'h0);
    rst = 1'b0;
    applyStimulus(0, 1, 0, 0, 0, 32'h0);
    tick();
    checkOutput("midrst_skid_empty", {31'b0, valid_ID}, 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    tick();
    tick();
    checkOutput("restart_pc_id", PC_ID, 32'h0);
    checkOutput("restart_valid", {31'b0, valid_ID}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
